// File: rtl/serial_uart_responder_if.sv
// rtl/serial_uart_responder_if.sv - processor-side serial port bundle
interface serial_uart_responder_if;
    logic [7:0] proc_data_in;
    logic       proc_wren_in;
    logic       proc_rden_in;
    logic [7:0] proc_data_out;
    logic       proc_valid_out;
    logic       proc_ready_out;

    modport master (
        output proc_data_in, proc_wren_in, proc_rden_in,
        input  proc_data_out, proc_valid_out, proc_ready_out
    );

    modport slave (
        input  proc_data_in, proc_wren_in, proc_rden_in,
        output proc_data_out, proc_valid_out, proc_ready_out
    );
endinterface

// File: rtl/serial_uart_responder.sv
// rtl/serial_uart_responder.sv - TX FIFO + 8N1 UART transmitter, UART receiver with one-byte holding register
module serial_uart_responder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_FIFO_AW   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    serial_uart_responder_if.slave  proc,
    input  logic                    uart_rx_in,
    output logic                    uart_tx_out,
    output logic                    rx_overrun_out,
    output logic                    rx_frame_out
);
    localparam int DEPTH = 1 << TX_FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]         BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]         HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TX_FIFO_AW:0]   FULL_CNT  = (TX_FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [TX_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TX_FIFO_AW:0]   count_q, count_d;
    logic                  push, pop, fifo_empty;

    tx_state_t   tx_state_q, tx_state_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic        tx_q, tx_d;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic        deliver;

    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_q, frame_d;

    assign fifo_empty          = (count_q == '0);
    assign proc.proc_ready_out = (count_q != FULL_CNT);
    assign push                = proc.proc_wren_in && proc.proc_ready_out;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // STOP chains straight into the next START so back-to-back frames have no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = mem_q[rd_ptr_q];
                        tx_state_d = TX_START;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_cnt_d   = rx_cnt_q;
        deliver    = 1'b0;
        frame_d    = frame_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        deliver    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_d    = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (deliver) begin
            if (!valid_q || proc.proc_rden_in) begin
                data_d  = rx_shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (proc.proc_rden_in && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= proc.proc_data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_cnt_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_q       <= tx_d;
            rx_s1_q    <= uart_rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_cnt_q   <= rx_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
        end
    end

    assign proc.proc_data_out  = data_q;
    assign proc.proc_valid_out = valid_q;
    assign uart_tx_out         = tx_q;
    assign rx_overrun_out      = overrun_q;
    assign rx_frame_out        = frame_q;
endmodule

// File: tb/tb_serial_uart_responder.sv
// tb/tb_serial_uart_responder.sv - directed bench for serial_uart_responder
module tb_serial_uart_responder;
    localparam int CPB = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic uart_rx_in = 1'b1;
    logic uart_tx_out, rx_overrun_out, rx_frame_out;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    serial_uart_responder_if pif();

    serial_uart_responder #(.CLKS_PER_BIT(CPB), .TX_FIFO_AW(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .proc           (pif),
        .uart_rx_in     (uart_rx_in),
        .uart_tx_out    (uart_tx_out),
        .rx_overrun_out (rx_overrun_out),
        .rx_frame_out   (rx_frame_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Drives one frame starting at a negedge; the final negedge wait spans the delivery edge.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic rd);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_in = fr[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx_in = 1'b1;
        pif.proc_rden_in = rd;
        @(negedge clock);
        pif.proc_rden_in = 1'b0;
    endtask

    task automatic recv_tx(output logic [7:0] b, output logic st, output int sc, output bit ok);
        ok = 1'b0; b = '0; st = 1'b0; sc = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (uart_tx_out === 1'b0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            sc = cyc;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(posedge clock); #1;
                b[k] = uart_tx_out;
            end
            repeat (CPB) @(posedge clock); #1;
            st = uart_tx_out;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (uart_tx_out !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", uart_tx_out); end
        vectors++; if (pif.proc_ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", pif.proc_ready_out); end
        vectors++; if (pif.proc_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", pif.proc_valid_out); end
        vectors++; if (pif.proc_data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", pif.proc_data_out); end
        vectors++; if (rx_overrun_out !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun_out); end
        vectors++; if (rx_frame_out !== 1'b0) begin miscompares++; $display("FAIL reset_frame: got %b expected 0", rx_frame_out); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_tx();
        int bad;
        pif.proc_data_in = 8'hA5; pif.proc_wren_in = 1'b1;
        @(negedge clock);
        pif.proc_wren_in = 1'b0;
        repeat (18) @(negedge clock);
        vectors++; if (uart_tx_out !== 1'b0) begin miscompares++; $display("FAIL midtx_bit3: got %b expected 0", uart_tx_out); end
        reset = 1'b0;
        #1;
        vectors++; if (uart_tx_out !== 1'b1) begin miscompares++; $display("FAIL midtx_async_tx: got %b expected 1", uart_tx_out); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (pif.proc_ready_out !== 1'b1) begin miscompares++; $display("FAIL midtx_ready: got %b expected 1", pif.proc_ready_out); end
        vectors++; if (pif.proc_valid_out !== 1'b0) begin miscompares++; $display("FAIL midtx_valid: got %b expected 0", pif.proc_valid_out); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            if (uart_tx_out !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midtx_quiet: got %0d low cycles expected 0", bad); end
        @(negedge clock);
    endtask

    task automatic test_single_tx();
        logic [9:0] fr;
        fr = {1'b1, 8'h53, 1'b0};
        pif.proc_data_in = 8'h53; pif.proc_wren_in = 1'b1;
        @(negedge clock);
        pif.proc_wren_in = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(posedge clock); #1;
            vectors++;
            if (uart_tx_out !== fr[i / CPB]) begin
                miscompares++;
                $display("FAIL tx53_cycle%0d: got %b expected %b", i, uart_tx_out, fr[i / CPB]);
            end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    pif.proc_data_in = 8'(i); pif.proc_wren_in = 1'b1;
                    vectors++; if (pif.proc_ready_out !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_w%0d: got %b expected 1", i, pif.proc_ready_out); end
                    @(negedge clock);
                end
                pif.proc_wren_in = 1'b0;
                vectors++; if (pif.proc_ready_out !== 1'b0) begin miscompares++; $display("FAIL b2b_full: got %b expected 0", pif.proc_ready_out); end
                pif.proc_data_in = 8'h99; pif.proc_wren_in = 1'b1;
                @(negedge clock);
                pif.proc_wren_in = 1'b0;
                vectors++; if (pif.proc_ready_out !== 1'b0) begin miscompares++; $display("FAIL b2b_drop_full: got %b expected 0", pif.proc_ready_out); end
            end
            begin
                logic [7:0] b;
                logic st;
                int sc, prev_sc;
                bit ok;
                prev_sc = 0;
                for (int k = 0; k < 9; k++) begin
                    recv_tx(b, st, sc, ok);
                    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_frame%0d_seen: got timeout expected frame", k); end
                    vectors++; if (b !== 8'(k)) begin miscompares++; $display("FAIL b2b_frame%0d_data: got %h expected %h", k, b, 8'(k)); end
                    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL b2b_frame%0d_stop: got %b expected 1", k, st); end
                    if (k > 0) begin
                        vectors++;
                        if (sc - prev_sc !== 10 * CPB) begin miscompares++; $display("FAIL b2b_frame%0d_gap: got %0d expected %0d", k, sc - prev_sc, 10 * CPB); end
                    end
                    prev_sc = sc;
                end
                recv_tx(b, st, sc, ok);
                vectors++; if (ok) begin miscompares++; $display("FAIL b2b_extra_frame: got frame %h expected none", b); end
            end
        join
        @(negedge clock);
    endtask

    task automatic test_rx_read();
        repeat (4) @(negedge clock);
        send_rx(8'h3C, 1'b1, 1'b0);
        vectors++; if (pif.proc_valid_out !== 1'b1) begin miscompares++; $display("FAIL rx3c_valid: got %b expected 1", pif.proc_valid_out); end
        vectors++; if (pif.proc_data_out !== 8'h3C) begin miscompares++; $display("FAIL rx3c_data: got %h expected 3c", pif.proc_data_out); end
        pif.proc_rden_in = 1'b1;
        @(negedge clock);
        pif.proc_rden_in = 1'b0;
        vectors++; if (pif.proc_valid_out !== 1'b0) begin miscompares++; $display("FAIL rx3c_read_valid: got %b expected 0", pif.proc_valid_out); end
        vectors++; if (pif.proc_data_out !== 8'h3C) begin miscompares++; $display("FAIL rx3c_read_data: got %h expected 3c", pif.proc_data_out); end
    endtask

    task automatic test_rx_overrun();
        repeat (4) @(negedge clock);
        send_rx(8'h11, 1'b1, 1'b0);
        repeat (4) @(negedge clock);
        send_rx(8'h22, 1'b1, 1'b0);
        vectors++; if (pif.proc_data_out !== 8'h11) begin miscompares++; $display("FAIL ovr_data: got %h expected 11", pif.proc_data_out); end
        vectors++; if (rx_overrun_out !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b expected 1", rx_overrun_out); end
        vectors++; if (pif.proc_valid_out !== 1'b1) begin miscompares++; $display("FAIL ovr_valid: got %b expected 1", pif.proc_valid_out); end
        do_reset();
        vectors++; if (rx_overrun_out !== 1'b0) begin miscompares++; $display("FAIL ovr_reset_clear: got %b expected 0", rx_overrun_out); end
        repeat (4) @(negedge clock);
        send_rx(8'h11, 1'b1, 1'b0);
        repeat (4) @(negedge clock);
        send_rx(8'h22, 1'b1, 1'b1);
        vectors++; if (pif.proc_data_out !== 8'h22) begin miscompares++; $display("FAIL replace_data: got %h expected 22", pif.proc_data_out); end
        vectors++; if (pif.proc_valid_out !== 1'b1) begin miscompares++; $display("FAIL replace_valid: got %b expected 1", pif.proc_valid_out); end
        vectors++; if (rx_overrun_out !== 1'b0) begin miscompares++; $display("FAIL replace_overrun: got %b expected 0", rx_overrun_out); end
    endtask

    task automatic test_rx_errors();
        pif.proc_rden_in = 1'b1;
        @(negedge clock);
        pif.proc_rden_in = 1'b0;
        vectors++; if (pif.proc_valid_out !== 1'b0) begin miscompares++; $display("FAIL err_clear_valid: got %b expected 0", pif.proc_valid_out); end
        repeat (4) @(negedge clock);
        uart_rx_in = 1'b0;
        @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (12) @(negedge clock);
        vectors++; if (pif.proc_valid_out !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b expected 0", pif.proc_valid_out); end
        vectors++; if (rx_frame_out !== 1'b0) begin miscompares++; $display("FAIL glitch_frame: got %b expected 0", rx_frame_out); end
        send_rx(8'hFF, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        vectors++; if (pif.proc_valid_out !== 1'b0) begin miscompares++; $display("FAIL frame_valid: got %b expected 0", pif.proc_valid_out); end
        vectors++; if (rx_frame_out !== 1'b1) begin miscompares++; $display("FAIL frame_flag: got %b expected 1", rx_frame_out); end
        vectors++; if (pif.proc_data_out !== 8'h22) begin miscompares++; $display("FAIL frame_data_kept: got %h expected 22", pif.proc_data_out); end
        send_rx(8'h5A, 1'b1, 1'b0);
        vectors++; if (pif.proc_data_out !== 8'h5A) begin miscompares++; $display("FAIL recover_data: got %h expected 5a", pif.proc_data_out); end
        vectors++; if (rx_frame_out !== 1'b1) begin miscompares++; $display("FAIL frame_sticky: got %b expected 1", rx_frame_out); end
    endtask

    initial begin
        pif.proc_data_in = 8'h00;
        pif.proc_wren_in = 1'b0;
        pif.proc_rden_in = 1'b0;
        test_reset();
        test_reset_mid_tx();
        test_single_tx();
        test_back_to_back();
        test_rx_read();
        test_rx_overrun();
        test_rx_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
